keypad_matrix_scanner: RTL and testbench
========================================

Name: keypad_matrix_scanner

Overview:
Parametrised successor to the fixed 4x4 keypad FSM. Scans a ROWS x COLS key matrix by driving columns one-hot and reading rows, and debounces both press and release over a configurable tick count. It flags simultaneous multi-key presses and emits single-cycle press and release events. It sits between the keypad pins and application logic such as counters and the FND display driver.

Parameters:
ROWS, 4, number of row inputs (>=2)
COLS, 4, number of column outputs (>=2)
DIV_BITS, 20, scan tick period = 2^DIV_BITS clk cycles (>=3)
DEBOUNCE_TICKS, 2, consecutive stable ticks required to accept a press or a release (>=1)
REPEAT_DELAY, 30, ticks from accepted press to first auto-repeat (KEYPAD_AUTOREPEAT_EN only)
REPEAT_RATE, 8, ticks between subsequent repeats (KEYPAD_AUTOREPEAT_EN only)
CODE_W (localparam), $clog2(ROWS*COLS), key code width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
row  in  ROWS  matrix row sense, active-high
col  out  COLS  column drive, one-hot, active-high
key_code  out  CODE_W  code of accepted key = col_index*ROWS + row_index
key_valid  out  1  high while an accepted key is held
key_press  out  1  one-clk pulse on accepted press (and on repeats)
key_release  out  1  one-clk pulse on accepted release
multi_key  out  1  high while more than one row is asserted during scan

Behaviour:
- Reset (async, reset_n=0): col=1 (bit0), state=SCAN, key_code=0, key_valid=0, key_press=0, key_release=0, multi_key=0, divider=0, debounce counter=0.
- row passes through a 2-flop synchroniser; all decisions use row_s.
- Divider free-runs. tick = 1 for one clk when divider is all ones. FSM transitions occur only on tick.
- Registered outputs change in the clk cycle after the tick edge. key_press and key_release are high for exactly one clk.
- SCAN:
  - row_s==0: col rotates left; bit COLS-1 wraps to bit0. multi_key cleared.
  - exactly one row_s bit set: capture row index and column index, debounce cnt=0, go to DEBOUNCE. col frozen.
  - >1 bit set: multi_key=1, col frozen, stay in SCAN.
- DEBOUNCE:
  - row_s equals captured one-hot: cnt++. When cnt reaches DEBOUNCE_TICKS: go to HELD, key_code=captured code, key_valid=1, key_press pulse.
  - otherwise: return to SCAN with col unchanged, no outputs.
- HELD: col frozen. If the captured row bit is 0 on a tick: cnt=0, go to RELEASE.
- RELEASE:
  - captured bit 0: cnt++. At DEBOUNCE_TICKS: key_valid=0, key_release pulse, go to SCAN, col advances one position.
  - captured bit returns to 1: go back to HELD, cnt=0, no pulse.
- key_code retains its last accepted value after release. It changes only on an accepted press.
- Other row bits asserting during HELD/RELEASE are ignored.
- Latency from a clean press on the driven column: 2 clk sync + (DEBOUNCE_TICKS+1) ticks max + 1 clk.
- reset_n asserted in any state aborts immediately to reset values. No release pulse is generated.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: in HELD, a tick counter starts at the accepted press. key_press pulses again after REPEAT_DELAY ticks, then every REPEAT_RATE ticks while held. The counter clears on entering RELEASE.
- Undefined: exactly one key_press per accepted press. REPEAT_* parameters are unused and no repeat logic is synthesised.

Test Plan:
- Common setup: DIV_BITS=4 (tick every 16 clk), DEBOUNCE_TICKS=2, ROWS=COLS=4. Bench models the matrix as row[r] = OR over c of (pressed[c][r] & col[c]).
- Reset: assert reset_n=0 mid-DEBOUNCE, asynchronously to clk -> col=4'b0001 and all outputs 0 within the same cycle; after release of reset, scanning order is 0001,0010,0100,1000,0001 on successive ticks.
- Single press: press (c=1,r=2) -> col frozen at 4'b0010; after 2 stable ticks key_press pulses for 1 clk; key_code=6, key_valid=1; no further pulses while held (macro off).
- Release: release the key after the single-press scenario -> after 2 ticks key_release pulses once; key_valid=0; key_code stays 6; col=4'b0100 on the next tick.
- Bounce: press (c=3,r=0) for one tick only -> no key_press, key_valid stays 0, scanning resumes from col 4'b1000. Release bounce (drop for 1 tick during RELEASE) -> no key_release.
- Multi-key: press (c=0,r=0) and (c=0,r=3) -> multi_key=1, col frozen at 4'b0001, no key_press. Release r=3 -> multi_key clears; press accepted with key_code=0.
- Auto-repeat (macro on, REPEAT_DELAY=4, REPEAT_RATE=2): hold (c=2,r=1) -> key_press at acceptance, again 4 ticks later, then every 2 ticks; key_code=9 throughout. Macro off -> exactly 1 pulse.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - debounced ROWS x COLS keypad matrix scanner; optional auto-repeat under KEYPAD_AUTOREPEAT_EN
module keypad_matrix_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int DIV_BITS       = 20,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int REPEAT_DELAY   = 30,
    parameter int REPEAT_RATE    = 8,
    localparam int CODE_W        = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_press,
    output logic              key_release,
    output logic              multi_key
);

    localparam int CNT_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RIDX_W = $clog2(ROWS);
    localparam int CIDX_W = $clog2(COLS);
    localparam int HIT_W  = $clog2(ROWS + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [ROWS-1:0]     row_m, row_s;
    logic [DIV_BITS-1:0] divider;
    logic                tick;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ROWS-1:0]     cap_row, cap_row_nxt;
    logic [CODE_W-1:0]   cap_code, cap_code_nxt;
    logic [COLS-1:0]     col_nxt, col_rot;
    logic [CODE_W-1:0]   key_code_nxt;
    logic                key_valid_nxt, key_press_nxt, key_release_nxt, multi_key_nxt;
    logic [HIT_W-1:0]    row_hits;
    logic [RIDX_W-1:0]   row_idx;
    logic [CIDX_W-1:0]   col_idx;
    logic                cap_bit;
    logic                rep_pulse;

    assign tick    = &divider;
    assign col_rot = {col[COLS-2:0], col[COLS-1]};
    assign cap_bit = |(row_s & cap_row);

    // Two-flop synchroniser on the asynchronous row pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_m <= '0;
            row_s <= '0;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    // Free-running scan divider; tick is its all-ones cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divider <= '0;
        end else begin
            divider <= divider + DIV_BITS'(1);
        end
    end

    // Row population count, index of the asserted row and index of the driven column
    always_comb begin
        row_hits = '0;
        row_idx  = '0;
        col_idx  = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (row_s[i]) begin
                row_hits = row_hits + HIT_W'(1);
                row_idx  = RIDX_W'(i);
            end
        end
        for (int j = 0; j < COLS; j++) begin
            if (col[j]) begin
                col_idx = CIDX_W'(j);
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt, rep_target;
    logic             rep_first;

    assign rep_target = rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE);
    assign rep_pulse  = (state == HELD) && tick && cap_bit && (rep_cnt + REP_W'(1) == rep_target);

    // Repeat timer: counts held ticks, first interval REPEAT_DELAY then REPEAT_RATE; cleared outside HELD
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (tick) begin
            if (state != HELD || !cap_bit) begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end else if (rep_pulse) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end
    end
`else
    localparam int unused_repeat_params = REPEAT_DELAY + REPEAT_RATE;

    assign rep_pulse = 1'b0;
`endif

    // Scanner FSM next-state and registered-output decisions, evaluated only on tick
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        cap_row_nxt     = cap_row;
        cap_code_nxt    = cap_code;
        col_nxt         = col;
        key_code_nxt    = key_code;
        key_valid_nxt   = key_valid;
        key_press_nxt   = 1'b0;
        key_release_nxt = 1'b0;
        multi_key_nxt   = multi_key;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_hits == '0) begin
                        col_nxt       = col_rot;
                        multi_key_nxt = 1'b0;
                    end else if (row_hits == HIT_W'(1)) begin
                        cap_row_nxt   = row_s;
                        cap_code_nxt  = CODE_W'(col_idx) * CODE_W'(ROWS) + CODE_W'(row_idx);
                        cnt_nxt       = '0;
                        multi_key_nxt = 1'b0;
                        state_nxt     = DEBOUNCE;
                    end else begin
                        multi_key_nxt = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (row_s == cap_row) begin
                        if (cnt == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                            cnt_nxt       = '0;
                            key_code_nxt  = cap_code;
                            key_valid_nxt = 1'b1;
                            key_press_nxt = 1'b1;
                            state_nxt     = HELD;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end else begin
                        state_nxt = SCAN;
                    end
                end
                HELD: begin
                    if (!cap_bit) begin
                        cnt_nxt   = '0;
                        state_nxt = RELEASE;
                    end else begin
                        key_press_nxt = rep_pulse;
                    end
                end
                RELEASE: begin
                    if (!cap_bit) begin
                        if (cnt == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                            cnt_nxt         = '0;
                            key_valid_nxt   = 1'b0;
                            key_release_nxt = 1'b1;
                            col_nxt         = col_rot;
                            state_nxt       = SCAN;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = HELD;
                    end
                end
                default: begin
                    state_nxt = SCAN;
                end
            endcase
        end
    end

    // FSM state, capture registers and outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SCAN;
            cnt         <= '0;
            cap_row     <= '0;
            cap_code    <= '0;
            col         <= COLS'(1);
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            multi_key   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cap_row     <= cap_row_nxt;
            cap_code    <= cap_code_nxt;
            col         <= col_nxt;
            key_code    <= key_code_nxt;
            key_valid   <= key_valid_nxt;
            key_press   <= key_press_nxt;
            key_release <= key_release_nxt;
            multi_key   <= multi_key_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - randomized self-checking bench for keypad_matrix_scanner
module tb_keypad_matrix_scanner;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int DIVB   = 4;
    localparam int DT     = 2;
    localparam int RD     = 4;
    localparam int RR     = 2;
    localparam int CODE_W = $clog2(ROWS * COLS);
    localparam int PERIOD = 1 << DIVB;
    localparam int VW     = COLS + CODE_W + 4;
    localparam int HOLD_T = 10;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int AR_PULSES = 1 + 1 + (HOLD_T - RD) / RR;
`else
    localparam int AR_PULSES = 1;
`endif

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic [ROWS-1:0]            row;
    logic [COLS-1:0]            col;
    logic [CODE_W-1:0]          key_code;
    logic                       key_valid, key_press, key_release, multi_key;
    logic [COLS-1:0][ROWS-1:0]  pressed = '0;
    logic [VW-1:0]              dut_vec;

    int n_cmp = 0;
    int n_bad = 0;
    int press_cnt = 0;
    int release_cnt = 0;
    int tb_div = 0;

    // reference model: key decided from streaks of identical tick samples
    int m_col, m_cand, m_streak, m_code, m_rel, m_since;
    int m_press_total = 0;
    int m_release_total = 0;
    bit m_valid, m_multi, exp_press, exp_release;

    keypad_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DIV_BITS(DIVB), .DEBOUNCE_TICKS(DT),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_press(key_press), .key_release(key_release),
        .multi_key(multi_key)
    );

    always #5 clk = ~clk;

    assign dut_vec = {col, key_code, key_valid, key_press, key_release, multi_key};

    // physical matrix: a row reads high when a pressed key sits on a driven column
    always_comb begin
        row = '0;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (pressed[c][r] && col[c]) row[r] = 1'b1;
    end

    // pulse counters and the bench's own view of the tick phase
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tb_div <= 0;
        end else begin
            tb_div <= (tb_div + 1) % PERIOD;
            if (key_press) press_cnt <= press_cnt + 1;
            if (key_release) release_cnt <= release_cnt + 1;
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        logic [COLS-1:0] c;
        c = '0;
        c[m_col] = 1'b1;
        return {c, CODE_W'(m_code), m_valid, exp_press, exp_release, m_multi};
    endfunction

    task automatic model_reset();
        m_col = 0; m_cand = -1; m_streak = 0; m_code = 0; m_rel = 0; m_since = 0;
        m_valid = 1'b0; m_multi = 1'b0; exp_press = 1'b0; exp_release = 1'b0;
    endtask

    task automatic model_tick();
        int n, rr, crow;
        n = 0; rr = 0;
        exp_press = 1'b0; exp_release = 1'b0;
        for (int r = 0; r < ROWS; r++) if (pressed[m_col][r]) begin n++; rr = r; end
        if (m_valid) begin
            crow = m_cand % ROWS;
            if (!pressed[m_col][crow]) begin
                m_rel++; m_since = 0;
                if (m_rel == DT + 1) begin
                    m_valid = 1'b0; exp_release = 1'b1; m_cand = -1; m_col = (m_col + 1) % COLS;
                end
            end else begin
                if (m_rel == 0) begin
                    m_since++;
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (m_since == RD || (m_since > RD && (m_since - RD) % RR == 0)) exp_press = 1'b1;
`endif
                end
                m_rel = 0;
            end
        end else if (m_cand >= 0) begin
            if (n == 1 && rr == m_cand % ROWS) begin
                m_streak++;
                if (m_streak == DT) begin
                    m_valid = 1'b1; m_code = m_cand; exp_press = 1'b1; m_rel = 0; m_since = 0;
                end
            end else begin
                m_cand = -1;
            end
        end else if (n == 0) begin
            m_col = (m_col + 1) % COLS; m_multi = 1'b0;
        end else if (n == 1) begin
            m_cand = m_col * ROWS + rr; m_streak = 0; m_multi = 1'b0;
        end else begin
            m_multi = 1'b1;
        end
        if (exp_press) m_press_total++;
        if (exp_release) m_release_total++;
    endtask

    task automatic step_tick();
        int guard;
        guard = 0;
        do begin
            @(posedge clk); #1; guard++;
        end while (tb_div != 0 && guard < 2 * PERIOD);
        if (tb_div != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL tick_align: phase %0d required 0", tb_div);
        end
        model_tick();
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic drain();
        int t;
        pressed = '0;
        t = 0;
        while ((m_valid || m_cand >= 0) && t < 12) begin step_tick(); t++; end
        if (m_valid || m_cand >= 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_bound: key still active after %0d ticks", t);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [COLS-1:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        pressed = '0; reset_n = 1'b0; model_reset();
        #23;
        n_cmp++;
        if (dut_vec !== {COLS'(1), CODE_W'(0), 4'b0000}) begin
            n_bad++; $display("FAIL reset_initial: got %h required %h", dut_vec, {COLS'(1), CODE_W'(0), 4'b0000});
        end
        release_reset();
        step_tick(); step_tick();
        pressed[2][1] = 1'b1;
        step_tick();
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL reset_capture: got %h required %h", dut_vec, exp_vec());
        end
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== {COLS'(1), CODE_W'(0), 4'b0000}) begin
            n_bad++; $display("FAIL reset_async: got %h required %h", dut_vec, {COLS'(1), CODE_W'(0), 4'b0000});
        end
        pressed = '0;
        release_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step_tick();
            n_cmp++;
            if (col !== order[i]) begin
                n_bad++; $display("FAIL reset_scan_order%0d: col %b required %b", i, col, order[i]);
            end
        end
    endtask

    task automatic test_single_press();
        int p0, mp0;
        bit hit;
        pressed = '0; pressed[1][2] = 1'b1;
        hit = 1'b0;
        for (int t = 0; t < 12 && !hit; t++) begin
            step_tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL single_press_t%0d: got %h required %h", t, dut_vec, exp_vec());
            end
            hit = exp_press;
        end
        n_cmp++;
        if ({col, key_code, key_valid, key_press} !== {4'b0010, CODE_W'(6), 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL single_press_accept: col %b code %0d valid %b press %b required 0010/6/1/1",
                              col, key_code, key_valid, key_press);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (key_press !== 1'b0) begin
            n_bad++; $display("FAIL single_press_width: key_press %b required 0", key_press);
        end
        p0 = press_cnt; mp0 = m_press_total;
        for (int t = 0; t < 6; t++) begin
            step_tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL single_hold_t%0d: got %h required %h", t, dut_vec, exp_vec());
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (press_cnt - p0 != m_press_total - mp0) begin
            n_bad++; $display("FAIL single_hold_pulses: %0d required %0d", press_cnt - p0, m_press_total - mp0);
        end
`ifndef KEYPAD_AUTOREPEAT_EN
        n_cmp++;
        if (press_cnt - p0 != 0) begin
            n_bad++; $display("FAIL single_no_repeat: %0d extra pulses required 0", press_cnt - p0);
        end
`endif
    endtask

    task automatic test_release();
        bit hit;
        int r0;
        r0 = release_cnt;
        pressed[1][2] = 1'b0;
        hit = 1'b0;
        for (int t = 0; t < 8 && !hit; t++) begin
            step_tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL release_t%0d: got %h required %h", t, dut_vec, exp_vec());
            end
            hit = exp_release;
        end
        n_cmp++;
        if ({col, key_code, key_valid, key_release} !== {4'b0100, CODE_W'(6), 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL release_event: col %b code %0d valid %b rel %b required 0100/6/0/1",
                              col, key_code, key_valid, key_release);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (key_release !== 1'b0 || release_cnt - r0 != 1) begin
            n_bad++; $display("FAIL release_width: rel %b count %0d required 0/1", key_release, release_cnt - r0);
        end
    endtask

    task automatic test_bounce();
        int p0, r0;
        for (int t = 0; t < 4 && m_col != 3; t++) step_tick();
        p0 = press_cnt;
        pressed = '0; pressed[3][0] = 1'b1;
        step_tick();
        pressed = '0;
        step_tick();
        n_cmp++;
        if ({col, key_valid, key_press} !== {4'b1000, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL bounce_press: col %b valid %b press %b required 1000/0/0", col, key_valid, key_press);
        end
        step_tick();
        n_cmp++;
        if (dut_vec !== exp_vec() || press_cnt != p0) begin
            n_bad++; $display("FAIL bounce_resume: got %h required %h pulses %0d", dut_vec, exp_vec(), press_cnt - p0);
        end
        pressed[0][1] = 1'b1;
        for (int t = 0; t < 8 && !m_valid; t++) step_tick();
        r0 = release_cnt;
        pressed[0][1] = 1'b0;
        step_tick();
        pressed[0][1] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step_tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL bounce_release_t%0d: got %h required %h", t, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (key_valid !== 1'b1 || release_cnt != r0) begin
            n_bad++; $display("FAIL bounce_no_release: valid %b releases %0d required 1/0", key_valid, release_cnt - r0);
        end
        drain();
    endtask

    task automatic test_multi_key();
        bit hit;
        int p0;
        p0 = press_cnt;
        pressed = '0; pressed[0][0] = 1'b1; pressed[0][3] = 1'b1;
        for (int t = 0; t < 6 && !m_multi; t++) step_tick();
        for (int t = 0; t < 2; t++) begin
            step_tick();
            n_cmp++;
            if ({multi_key, col, key_press, key_valid} !== {1'b1, 4'b0001, 1'b0, 1'b0} || dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL multi_frozen_t%0d: got %h required %h", t, dut_vec, exp_vec());
            end
        end
        pressed[0][3] = 1'b0;
        step_tick();
        n_cmp++;
        if (multi_key !== 1'b0 || dut_vec !== exp_vec()) begin
            n_bad++; $display("FAIL multi_clear: got %h required %h", dut_vec, exp_vec());
        end
        hit = 1'b0;
        for (int t = 0; t < 6 && !hit; t++) begin step_tick(); hit = exp_press; end
        n_cmp++;
        if ({key_code, key_valid, key_press} !== {CODE_W'(0), 1'b1, 1'b1} || press_cnt != p0) begin
            n_bad++; $display("FAIL multi_accept: code %0d valid %b press %b early pulses %0d required 0/1/1/0",
                              key_code, key_valid, key_press, press_cnt - p0);
        end
        drain();
    endtask

    task automatic test_autorepeat();
        int p0;
        bit hit;
        p0 = press_cnt;
        pressed = '0; pressed[2][1] = 1'b1;
        hit = 1'b0;
        for (int t = 0; t < 12 && !hit; t++) begin step_tick(); hit = exp_press; end
        for (int t = 0; t < HOLD_T; t++) begin
            step_tick();
            n_cmp++;
            if (dut_vec !== exp_vec() || key_code !== CODE_W'(9)) begin
                n_bad++; $display("FAIL autorepeat_t%0d: got %h required %h", t, dut_vec, exp_vec());
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (press_cnt - p0 != AR_PULSES) begin
            n_bad++; $display("FAIL autorepeat_pulses: %0d required %0d", press_cnt - p0, AR_PULSES);
        end
        drain();
    endtask

    task automatic test_random();
        int c, r;
        pressed = '0;
        for (int t = 0; t < 160; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                c = $urandom_range(0, COLS - 1);
                r = $urandom_range(0, ROWS - 1);
                pressed[c][r] = ~pressed[c][r];
            end
            step_tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL random_t%0d: got %h required %h", t, dut_vec, exp_vec());
            end
        end
        drain();
        n_cmp++;
        if (press_cnt != m_press_total || release_cnt != m_release_total) begin
            n_bad++; $display("FAIL pulse_totals: press %0d release %0d required %0d/%0d",
                              press_cnt, release_cnt, m_press_total, m_release_total);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_release();
        test_bounce();
        test_multi_key();
        test_autorepeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
